// File: rtl/timer_pkg.sv
// Shared types and constants for the multimode_timer timekeeping core.
package timer_pkg;

    typedef enum logic [1:0] {
        MODE_TIMER     = 2'd0,
        MODE_STOPWATCH = 2'd1,
        MODE_CLOCK     = 2'd2,
        MODE_ALARM     = 2'd3
    } mode_e;

    // Centiseconds in one day; time-of-day wraps at this count.
    localparam int DEFAULT_DAY_TICKS = 8640000;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle centisecond tick every TICK_DIV clocks.
module tick_divider #(
    parameter int TICK_DIV = 100000
) (
    input  logic clockSignal,
    input  logic splitOrReset,
    output logic o_tick
);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] r_cnt;

    // Count 0..TICK_DIV-1 and wrap.
    always_ff @(posedge clockSignal or posedge splitOrReset) begin
        if (splitOrReset)       r_cnt <= '0;
        else if (r_cnt == LAST) r_cnt <= '0;
        else                    r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/multimode_timer.sv
// Four-function timekeeper: countdown timer, stopwatch with laps, time of day, alarm.
// All functions run concurrently; mode only selects the display and load target.
// Build option: define LAP_BUFFER_EN for a LAP_DEPTH-entry lap FIFO; otherwise a
// single overwrite-on-push lap register is used.
module multimode_timer
    import timer_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int TICK_DIV  = 100000,
    parameter int LAP_DEPTH = 4,
    parameter int DAY_TICKS = DEFAULT_DAY_TICKS
) (
    input  logic                           clockSignal,
    input  logic                           splitOrReset,
    input  logic                           mode_pulse,
    input  logic                           start_pulse,
    input  logic                           lap_pulse,
    input  logic                           load_en,
    input  logic [CNT_W-1:0]               load_val,
    input  logic                           lap_rd,
    output logic [1:0]                     mode,
    output logic [CNT_W-1:0]               display_val,
    output logic                           running,
    output logic                           ring,
    output logic [CNT_W-1:0]               lap_val,
    output logic                           lap_valid,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count
);
    localparam int CW = $clog2(LAP_DEPTH+1);
    localparam logic [CNT_W-1:0] DAY_LIM = CNT_W'(DAY_TICKS);
    localparam logic [CNT_W-1:0] DAY_MAX = CNT_W'(DAY_TICKS - 1);

    mode_e            r_mode;
    logic [CNT_W-1:0] r_cd_val, r_sw_val, r_tod, r_alarm_time;
    logic             r_cd_run, r_sw_run, r_alarm_armed, r_ring;

    logic             w_tick;
    logic             w_in_t, w_in_s, w_in_c, w_in_a;
    logic             w_start, w_dismiss, w_load_ok;
    logic             w_cd_load, w_cd_tog, w_cd_clr, w_cd_dec, w_cd_expire;
    logic             w_sw_tog, w_sw_inc, w_lap_push, w_lap_flush;
    logic             w_tod_load, w_al_load, w_al_tog, w_alarm_hit;
    logic [CNT_W-1:0] w_tod_inc;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_div (
        .clockSignal  (clockSignal),
        .splitOrReset (splitOrReset),
        .o_tick       (w_tick)
    );

    assign w_in_t    = (r_mode == MODE_TIMER);
    assign w_in_s    = (r_mode == MODE_STOPWATCH);
    assign w_in_c    = (r_mode == MODE_CLOCK);
    assign w_in_a    = (r_mode == MODE_ALARM);
    // A start while ringing is only a dismiss.
    assign w_dismiss = start_pulse & r_ring;
    assign w_start   = start_pulse & ~r_ring;
    assign w_load_ok = (load_val < DAY_LIM);

    assign w_cd_load   = w_in_t & load_en;
    assign w_cd_tog    = w_in_t & w_start & (r_cd_val != '0) & ~w_cd_load;
    assign w_cd_clr    = w_in_t & lap_pulse & ~r_cd_run & ~w_cd_load & ~w_cd_tog;
    assign w_cd_dec    = r_cd_run & w_tick & ~w_cd_load & ~w_cd_tog;
    assign w_cd_expire = w_cd_dec & (r_cd_val == CNT_W'(1));

    assign w_sw_tog    = w_in_s & w_start;
    assign w_lap_push  = w_in_s & lap_pulse & r_sw_run & ~w_sw_tog;
    assign w_lap_flush = w_in_s & lap_pulse & ~r_sw_run & ~w_sw_tog;
    assign w_sw_inc    = r_sw_run & w_tick & ~w_sw_tog & (r_sw_val != '1);

    assign w_tod_load  = w_in_c & load_en & w_load_ok;
    assign w_tod_inc   = (r_tod == DAY_MAX) ? '0 : r_tod + 1'b1;
    assign w_al_load   = w_in_a & load_en & w_load_ok;
    assign w_al_tog    = w_in_a & w_start & ~w_al_load;
    assign w_alarm_hit = w_tick & ~w_tod_load & r_alarm_armed & (w_tod_inc == r_alarm_time);

    // Mode select and sticky ring; a new trigger outranks a same-cycle dismiss.
    always_ff @(posedge clockSignal or posedge splitOrReset) begin
        if (splitOrReset) begin
            r_mode <= MODE_TIMER;
            r_ring <= 1'b0;
        end else begin
            if (mode_pulse) r_mode <= mode_e'(r_mode + 2'd1);
            if (w_cd_expire | w_alarm_hit) r_ring <= 1'b1;
            else if (w_dismiss)            r_ring <= 1'b0;
        end
    end

    // Countdown timer: load > start > lap-clear > tick.
    always_ff @(posedge clockSignal or posedge splitOrReset) begin
        if (splitOrReset) begin
            r_cd_val <= '0;
            r_cd_run <= 1'b0;
        end else if (w_cd_load) begin
            r_cd_val <= load_val;
            r_cd_run <= 1'b0;
        end else if (w_cd_tog) begin
            r_cd_run <= ~r_cd_run;
        end else if (w_cd_clr) begin
            r_cd_val <= '0;
        end else if (w_cd_dec) begin
            r_cd_val <= r_cd_val - 1'b1;
            if (w_cd_expire) r_cd_run <= 1'b0;
        end
    end

    // Stopwatch: saturating up-count, cleared by a lap while stopped.
    always_ff @(posedge clockSignal or posedge splitOrReset) begin
        if (splitOrReset) begin
            r_sw_val <= '0;
            r_sw_run <= 1'b0;
        end else if (w_sw_tog) begin
            r_sw_run <= ~r_sw_run;
        end else if (w_lap_flush) begin
            r_sw_val <= '0;
        end else if (w_sw_inc) begin
            r_sw_val <= r_sw_val + 1'b1;
        end
    end

    // Time of day and alarm; out-of-range loads are dropped.
    always_ff @(posedge clockSignal or posedge splitOrReset) begin
        if (splitOrReset) begin
            r_tod         <= '0;
            r_alarm_time  <= '0;
            r_alarm_armed <= 1'b0;
        end else begin
            if (w_tod_load)  r_tod <= load_val;
            else if (w_tick) r_tod <= w_tod_inc;
            if (w_al_load) begin
                r_alarm_time  <= load_val;
                r_alarm_armed <= 1'b1;
            end else if (w_al_tog) begin
                r_alarm_armed <= ~r_alarm_armed;
            end
        end
    end

`ifdef LAP_BUFFER_EN
    localparam int PW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    logic [CNT_W-1:0] r_lap_mem [LAP_DEPTH];
    logic [PW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]    r_lap_cnt;
    logic             w_pop, w_full;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(LAP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = lap_rd & (r_lap_cnt != '0);
    assign w_full = (r_lap_cnt == CW'(LAP_DEPTH));

    // Circular lap FIFO; a push into a full buffer evicts the oldest entry.
    always_ff @(posedge clockSignal or posedge splitOrReset) begin
        if (splitOrReset) begin
            for (int i = 0; i < LAP_DEPTH; i++) r_lap_mem[i] <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_lap_cnt <= '0;
        end else if (w_lap_flush) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_lap_cnt <= '0;
        end else begin
            if (w_lap_push) begin
                r_lap_mem[r_wr_ptr] <= r_sw_val;
                r_wr_ptr            <= f_next(r_wr_ptr);
            end
            if ((w_lap_push & w_full) | w_pop) r_rd_ptr <= f_next(r_rd_ptr);
            if (w_lap_push & ~w_pop & ~w_full) r_lap_cnt <= r_lap_cnt + 1'b1;
            else if (w_pop & ~w_lap_push)      r_lap_cnt <= r_lap_cnt - 1'b1;
        end
    end

    assign lap_valid = (r_lap_cnt != '0);
    assign lap_count = r_lap_cnt;
    assign lap_val   = lap_valid ? r_lap_mem[r_rd_ptr] : '0;
`else
    logic [CNT_W-1:0] r_lap_reg;
    logic             r_lap_vld;

    // Single lap register; a push overwrites and wins over a same-cycle read.
    always_ff @(posedge clockSignal or posedge splitOrReset) begin
        if (splitOrReset) begin
            r_lap_reg <= '0;
            r_lap_vld <= 1'b0;
        end else if (w_lap_flush) begin
            r_lap_reg <= '0;
            r_lap_vld <= 1'b0;
        end else if (w_lap_push) begin
            r_lap_reg <= r_sw_val;
            r_lap_vld <= 1'b1;
        end else if (lap_rd) begin
            r_lap_vld <= 1'b0;
        end
    end

    assign lap_valid = r_lap_vld;
    assign lap_count = CW'(r_lap_vld);
    assign lap_val   = r_lap_vld ? r_lap_reg : '0;
`endif

    assign mode = r_mode;
    assign ring = r_ring;

    // Display and running flag follow the selected function.
    always_comb begin
        display_val = r_cd_val;
        running     = 1'b0;
        case (r_mode)
            MODE_TIMER:     begin display_val = r_cd_val;     running = r_cd_run;      end
            MODE_STOPWATCH: begin display_val = r_sw_val;     running = r_sw_run;      end
            MODE_CLOCK:     begin display_val = r_tod;        running = 1'b0;          end
            MODE_ALARM:     begin display_val = r_alarm_time; running = r_alarm_armed; end
            default:        begin display_val = r_cd_val;     running = 1'b0;          end
        endcase
    end
endmodule

// File: tb/tb_multimode_timer.sv
// Self-checking bench for multimode_timer: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_multimode_timer;
    localparam int CW = 16, TD = 4, DT = 100, LD = 2;
`ifdef LAP_BUFFER_EN
    localparam int MDEPTH = LD;
`else
    localparam int MDEPTH = 1;
`endif

    logic          clockSignal = 1'b0, splitOrReset = 1'b0;
    logic          mode_pulse = 1'b0, start_pulse = 1'b0, lap_pulse = 1'b0;
    logic          load_en = 1'b0, lap_rd = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic [1:0]    mode;
    logic [CW-1:0] display_val, lap_val;
    logic          running, ring, lap_valid;
    logic [1:0]    lap_count;

    multimode_timer #(.CNT_W(CW), .TICK_DIV(TD), .LAP_DEPTH(LD), .DAY_TICKS(DT)) dut (
        .clockSignal(clockSignal), .splitOrReset(splitOrReset), .mode_pulse(mode_pulse),
        .start_pulse(start_pulse), .lap_pulse(lap_pulse), .load_en(load_en),
        .load_val(load_val), .lap_rd(lap_rd), .mode(mode), .display_val(display_val),
        .running(running), .ring(ring), .lap_val(lap_val), .lap_valid(lap_valid),
        .lap_count(lap_count)
    );

    always #5 clockSignal = ~clockSignal;

    int n_cmp = 0, n_bad = 0;

    // Behavioural model state
    int  m_edges, m_mode, m_cd, m_sw, m_tod, m_alarm;
    bit  m_cdrun, m_swrun, m_armed, m_ring;
    int  m_laps[$];

    typedef struct {
        bit mp, st, lp, ld; int lv; bit rd;
        int e_mode, e_disp; bit e_run, e_ring;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_edges = 0; m_mode = 0; m_cd = 0; m_sw = 0; m_tod = 0; m_alarm = 0;
        m_cdrun = 0; m_swrun = 0; m_armed = 0; m_ring = 0;
        m_laps.delete();
    endtask

    function automatic int m_disp();
        case (m_mode)
            0: return m_cd;
            1: return m_sw;
            2: return m_tod;
            default: return m_alarm;
        endcase
    endfunction

    function automatic bit m_running();
        case (m_mode)
            0: return m_cdrun;
            1: return m_swrun;
            3: return m_armed;
            default: return 1'b0;
        endcase
    endfunction

    // One clock of the specified behaviour, from the inputs currently driven.
    task automatic model_step();
        bit tick, dis, st, ring_n, push, flush;
        int lv, pv;
        tick   = (m_edges % TD) == TD - 1;
        dis    = start_pulse && m_ring;
        st     = start_pulse && !m_ring;
        ring_n = m_ring && !dis;
        lv     = int'(load_val);
        pv     = m_sw;
        push   = 0;
        flush  = 0;
        if (m_mode == 0 && load_en) begin m_cd = lv; m_cdrun = 0; end
        else if (m_mode == 0 && st) begin if (m_cd != 0) m_cdrun = !m_cdrun; end
        else if (m_mode == 0 && lap_pulse && !m_cdrun) m_cd = 0;
        else if (m_cdrun && tick) begin
            m_cd--;
            if (m_cd == 0) begin m_cdrun = 0; ring_n = 1; end
        end
        if (m_mode == 1 && st) m_swrun = !m_swrun;
        else begin
            flush = (m_mode == 1) && lap_pulse && !m_swrun;
            push  = (m_mode == 1) && lap_pulse && m_swrun;
            if (flush) m_sw = 0;
            else if (m_swrun && tick && m_sw < (1 << CW) - 1) m_sw++;
        end
        if (flush) m_laps.delete();
        else begin
            if (lap_rd && m_laps.size() > 0) void'(m_laps.pop_front());
            if (push) begin
                m_laps.push_back(pv);
                if (m_laps.size() > MDEPTH) void'(m_laps.pop_front());
            end
        end
        if (m_mode == 2 && load_en && lv < DT) m_tod = lv;
        else if (tick) begin
            m_tod = (m_tod + 1) % DT;
            if (m_armed && m_tod == m_alarm) ring_n = 1;
        end
        if (m_mode == 3 && load_en && lv < DT) begin m_alarm = lv; m_armed = 1; end
        else if (m_mode == 3 && st) m_armed = !m_armed;
        m_ring = ring_n;
        if (mode_pulse) m_mode = (m_mode + 1) % 4;
        m_edges++;
    endtask

    // Drive one cycle of inputs (called at posedge+1, returns at next posedge+1).
    task automatic cyc(input bit mp, input bit st, input bit lp, input bit ld,
                       input int lv, input bit rd);
        mode_pulse = mp; start_pulse = st; lap_pulse = lp; load_en = ld;
        load_val = lv[CW-1:0]; lap_rd = rd;
        model_step();
        @(posedge clockSignal); #1;
        mode_pulse = 0; start_pulse = 0; lap_pulse = 0; load_en = 0; lap_rd = 0;
        load_val = '0;
    endtask

    task automatic idle(); cyc(0, 0, 0, 0, 0, 0); endtask

    task automatic chk_model(input string tag);
        chk({tag, ".mode"},    32'(mode),        32'(m_mode));
        chk({tag, ".disp"},    32'(display_val), 32'(m_disp()));
        chk({tag, ".running"}, 32'(running),     32'(m_running()));
        chk({tag, ".ring"},    32'(ring),        32'(m_ring));
        chk({tag, ".lapvld"},  32'(lap_valid),   32'(m_laps.size() > 0));
        chk({tag, ".lapcnt"},  32'(lap_count),   32'(m_laps.size()));
        if (m_laps.size() > 0) chk({tag, ".lapval"}, 32'(lap_val), 32'(m_laps[0]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".mode"},   32'(mode),        0);
        chk({tag, ".disp"},   32'(display_val), 0);
        chk({tag, ".run"},    32'(running),     0);
        chk({tag, ".ring"},   32'(ring),        0);
        chk({tag, ".lapvld"}, 32'(lap_valid),   0);
        chk({tag, ".lapcnt"}, 32'(lap_count),   0);
    endtask

    task automatic do_reset();
        splitOrReset = 1;
        @(posedge clockSignal); #1;
        splitOrReset = 0;
        model_reset();
    endtask

    // Run idle cycles until the model's stopwatch reaches target.
    task automatic wait_sw(input int target, input string tag);
        int g = 0;
        while (m_sw != target && g < 200) begin idle(); g++; end
        chk({tag, ".reached"}, 32'(m_sw == target), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        // Reset state
        #1 splitOrReset = 1;
        #1 chk_zero("reset");
        @(posedge clockSignal); #1;
        splitOrReset = 0;
        model_reset();

        // Directed timer expiry table, starting right after reset release.
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b1, 3,1'b0, 0,3,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b0, 0,1'b0, 0,3,1'b1,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,3,1'b1,1'b0};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,2,1'b1,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,2,1'b1,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,2,1'b1,1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,2,1'b1,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,1,1'b1,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,1,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,1,1'b1,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,1,1'b1,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0, 0,1'b0, 0,0,1'b0,1'b1};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b0, 0,1'b0, 0,0,1'b0,1'b0};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0, 0,1'b0, 1,0,1'b0,1'b0};
        tbl[14] = '{1'b1,1'b0,1'b0,1'b0, 0,1'b0, 2,3,1'b0,1'b0};
        tbl[15] = '{1'b1,1'b0,1'b0,1'b0, 0,1'b0, 3,0,1'b0,1'b0};
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].mp, tbl[i].st, tbl[i].lp, tbl[i].ld, tbl[i].lv, tbl[i].rd);
            chk($sformatf("tbl%0d.mode", i), 32'(mode),        32'(tbl[i].e_mode));
            chk($sformatf("tbl%0d.disp", i), 32'(display_val), 32'(tbl[i].e_disp));
            chk($sformatf("tbl%0d.run", i),  32'(running),     32'(tbl[i].e_run));
            chk($sformatf("tbl%0d.ring", i), 32'(ring),        32'(tbl[i].e_ring));
        end

        // Stopwatch laps at 5, 7, 9
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("sw.running", 32'(running), 1);
        wait_sw(5, "sw5"); cyc(0, 0, 1, 0, 0, 0);
        wait_sw(7, "sw7"); cyc(0, 0, 1, 0, 0, 0);
        wait_sw(9, "sw9"); cyc(0, 0, 1, 0, 0, 0);
        chk("lap.count3", 32'(lap_count), (MDEPTH == 2) ? 2 : 1);
        chk("lap.head3",  32'(lap_val),   (MDEPTH == 2) ? 7 : 9);
        chk_model("lap3");
        cyc(0, 0, 0, 0, 0, 1);
        chk("lap.rd_vld", 32'(lap_valid), (MDEPTH == 2) ? 1 : 0);
        if (MDEPTH == 2) chk("lap.rd_head", 32'(lap_val), 9);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("sw.clear_disp", 32'(display_val), 0);
        chk("sw.clear_vld",  32'(lap_valid),   0);
        chk_model("swclr");

        // Clock wrap and alarm at tod 0
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 98, 0);
        chk("tod.load98", 32'(display_val), 98);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("alarm.disp",  32'(display_val), 0);
        chk("alarm.armed", 32'(running),     1);
        g = 0;
        while (!m_ring && g < 20) begin idle(); chk_model("alwait"); g++; end
        chk("alarm.ring", 32'(ring), 1);
        cyc(0, 1, 0, 0, 0, 0);
        chk("alarm.dismiss", 32'(ring),    0);
        chk("alarm.still",   32'(running), 1);
        cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 150, 0);
        chk("tod.badload", 32'(display_val), 32'(m_tod));
        chk_model("clk");

        // Simultaneous load and start in timer mode
        do_reset();
        cyc(0, 0, 0, 1, 5, 0);
        cyc(0, 1, 0, 1, 10, 0);
        chk("ldst.disp", 32'(display_val), 10);
        chk("ldst.run",  32'(running),     0);
        cyc(0, 1, 0, 0, 0, 0);
        chk("ldst.start", 32'(running), 1);

        // Reset mid-run
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        wait_sw(6, "rst6");
        chk("rst.pre", 32'(display_val), 6);
        #2 splitOrReset = 1;
        #1 chk_zero("midrst");
        @(posedge clockSignal); #1;
        splitOrReset = 0;
        model_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst.tod_e2", 32'(display_val), 0);
        idle();
        chk("rst.tod_e3", 32'(display_val), 0);
        idle();
        chk("rst.tod_e4", 32'(display_val), 1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int op, lv;
            bit mp, rd;
            op = $urandom_range(0, 15);
            mp = ($urandom_range(0, 7) == 0);
            rd = ($urandom_range(0, 5) == 0);
            lv = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 129) : $urandom_range(0, 30);
            if (op < 2)       cyc(mp, 1, 0, 0, 0, rd);
            else if (op < 5)  cyc(mp, 0, 1, 0, 0, rd);
            else if (op < 6)  cyc(mp, 0, 0, 1, lv, rd);
            else              cyc(mp, 0, 0, 0, 0, rd);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multimode_timer.md
# multimode_timer

Parametrised four-mode timekeeping core: countdown timer, stopwatch with lap capture, time-of-day clock and time-of-day alarm, all counting in centisecond ticks derived from clockSignal. All four functions run concurrently in the background. `mode` selects only which value appears on `display_val` and which function `load_en` targets. It sits between the button synchroniser/one-shot logic and the display decoder.

## Interface
- CNT_W, 32: width of all centisecond counters and values.
- TICK_DIV, 100000: clockSignal cycles per 10 ms tick (must be ≥ 2).
- LAP_DEPTH, 4: lap FIFO entries.
- DAY_TICKS, 8640000: centiseconds per day; time-of-day wraps here.

Ports:
- clockSignal  in  1  system clock.
- splitOrReset  in  1  reset, asynchronous, active-high.
- mode_pulse  in  1  one-cycle pulse; mode ← mode+1, wrapping 3→0.
- start_pulse  in  1  one-cycle pulse; start/stop for the current mode, or ring dismiss.
- lap_pulse  in  1  one-cycle pulse; lap capture, or stopwatch clear.
- load_en  in  1  load `load_val` into the mode's target register.
- load_val  in  CNT_W  load data.
- lap_rd  in  1  pop the lap FIFO head.
- mode  out  2  0 timer, 1 stopwatch, 2 clock, 3 alarm.
- display_val  out  CNT_W  selected value: cd_val / sw_val / tod / alarm_time.
- running  out  1  cd_run in mode 0, sw_run in mode 1, alarm_armed in mode 3, 0 in mode 2.
- ring  out  1  sticky alarm/timer-expiry indication.
- lap_val  out  CNT_W  FIFO head.
- lap_valid  out  1  FIFO non-empty.
- lap_count  out  $clog2(LAP_DEPTH+1)  current entry count.

## Operation
- **Reset values.** Every register and output resets to 0: mode, cd_val, sw_val, tod, alarm_time, run flags, alarm_armed, ring, FIFO, and the divider.
- **Tick.** The divider counts 0..TICK_DIV-1 freely. `tick` is high for one cycle when the count equals TICK_DIV-1.
- **Time-of-day (tod).** tod increments on every tick and wraps DAY_TICKS-1 → 0.
  - In mode 2, `load_en` with load_val < DAY_TICKS sets tod.
  - A load_val ≥ DAY_TICKS is ignored.
- **Timer.**
  - In mode 0, `load_en` sets cd_val and clears cd_run.
  - In mode 0, `start_pulse` toggles cd_run, but only if cd_val ≠ 0.
  - While cd_run is set, each tick decrements cd_val.
  - The tick that takes cd_val 1→0 also clears cd_run and sets ring, all on the same edge.
  - In mode 0, `lap_pulse` while stopped clears cd_val.
- **Stopwatch.**
  - In mode 1, `start_pulse` toggles sw_run.
  - While sw_run is set, each tick increments sw_val; sw_val saturates at 2^CNT_W-1.
  - In mode 1, `lap_pulse` while running pushes sw_val into the FIFO.
  - In mode 1, `lap_pulse` while stopped clears sw_val and empties the FIFO.
- **Alarm.**
  - In mode 3, `load_en` with load_val < DAY_TICKS sets alarm_time and sets alarm_armed; an out-of-range load is ignored.
  - In mode 3, `start_pulse` toggles alarm_armed.
  - On a tick where alarm_armed=1 and the incremented tod equals alarm_time, ring is set.
  - The alarm stays armed, so it fires again daily.
- **Ring.** ring is sticky.
  - A `start_pulse` while ring=1 clears ring, in any mode.
  - That pulse is consumed as a dismiss and has no other effect.
- **Priorities.**
  - Pulses apply only to the mode selected in that cycle. A simultaneous `mode_pulse` takes effect for the following cycle.
  - `load_en` beats `start_pulse`, which beats `tick`, for the same register.
  - Countdown expiry and a start-dismiss in the same cycle: ring ends up set.
- **FIFO.**
  - Push when full drops the oldest entry; lap_count stays at LAP_DEPTH.
  - Push and pop in the same cycle: both happen, and the count is unchanged.
  - Pop when empty is ignored.

## Timing
- The first tick occurs on cycle TICK_DIV after reset release.
- A start takes effect on the next edge; the first count happens on the following tick.
- display_val, running, lap_val, lap_valid and lap_count are combinational from registers, so they have zero cycle latency from the register update.
- ring rises on the same edge as the triggering tick update.
- Reset asserted mid-count clears all state asynchronously; counting resumes only after a fresh TICK_DIV cycles.

## Configuration
- **With LAP_BUFFER_EN defined:** LAP_DEPTH-entry circular FIFO, behaving as described above.
- **Without LAP_BUFFER_EN:**
  - A single lap register replaces the FIFO.
  - Each push overwrites it and sets lap_valid; `lap_rd` clears lap_valid.
  - lap_count is 0 or 1, and LAP_DEPTH is ignored.

## Structure
- **Package `timer_pkg`:** mode enum (MODE_TIMER, MODE_STOPWATCH, MODE_CLOCK, MODE_ALARM) and the default DAY_TICKS constant.
- **Sub-module `tick_divider`:** parameter TICK_DIV, outputs a one-cycle `tick`.
- The lap FIFO stays inline under the macro.

## Test plan
All scenarios use TICK_DIV=4, DAY_TICKS=100, CNT_W=16, LAP_DEPTH=2.
- **Timer expiry:** mode 0, load 3, start → cd_val goes 2,1,0 on successive ticks; ring=1 and running=0 at the 0 edge; a start_pulse clears ring with cd_run still 0.
- **Stopwatch laps:** mode 1, start, lap at sw_val 5, 7, 9 → lap_count=2, FIFO holds 7 then 9 (5 dropped); lap_rd → lap_val=9; stop then lap → sw_val=0, lap_valid=0.
- **Clock wrap and alarm:** mode 2, load 98; mode 3, load 0 → the tick taking tod 99→0 sets ring; a clock-mode load of 150 is ignored.
- **Simultaneous load and start:** mode 0, load_en=1 with load_val=10 and start_pulse=1 in the same cycle → cd_val=10, running=0.
- **Reset mid-run:** stopwatch running at sw_val=6, assert splitOrReset → all outputs 0 immediately; no tick until 4 cycles after release.
- **Macro off:** without LAP_BUFFER_EN, two laps → lap_count=1, lap_val equals the second lap.
